reg_file_sb: RTL and testbench

- Parametrised successor to the core's integer register file, with two synchronous read ports and one write port.
- Register 0 is hardwired to zero.
- Same-cycle write-to-read bypass.
- Per-register busy scoreboard: the decode stage uses it to detect RAW hazards against in-flight writebacks.
- Sits between decode (rs1/rs2/issue) and writeback (writereg/rd/writedata).

---
 rtl/reg_file_sb.sv | 128 ++++++++++++
 tb/tb_reg_file_sb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Integer register file: two registered read ports, one write port with
// write-first bypass, and a per-register busy scoreboard that decode uses
// to detect RAW hazards against in-flight writebacks.

// One architectural register plus its busy bit.
module reg_file_sb_entry #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  input  logic            set_busy,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  logic [XLEN-1:0] data_d, data_q;
  logic            busy_d, busy_q;

  // Next state: a write clears busy, but a same-cycle issue re-marks it
  // because the newly issued producer supersedes the one retiring now.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (wr_en) begin
      data_d = wr_data;
      busy_d = 1'b0;
    end
    if (set_busy) busy_d = 1'b1;
  end

  // State register; reset wins over any same-cycle write or issue.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data = data_q;
  assign busy = busy_q;

endmodule

module reg_file_sb #(
  parameter int  XLEN     = 32,
  parameter int  NREGS    = 32,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             writereg,
  input  logic [AW-1:0]    rd,
  input  logic [XLEN-1:0]  writedata,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [XLEN-1:0]  readdata1,
  output logic [XLEN-1:0]  readdata2,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             hazard,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0][XLEN-1:0] data_vec;
  logic [XLEN-1:0]            rdata1_d, rdata1_q;
  logic [XLEN-1:0]            rdata2_d, rdata2_q;

  // Register 0 in zero mode has no storage at all: it reads 0, ignores
  // writes and can never be marked busy.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (ZERO_REG && i == 0) begin : g_zero
      assign data_vec[i] = '0;
      assign busy_vec[i] = 1'b0;
    end else begin : g_ent
      reg_file_sb_entry #(.XLEN(XLEN)) u_ent (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (writereg && (rd == AW'(i))),
        .wr_data  (writedata),
        .set_busy (issue_valid && (issue_rd == AW'(i))),
        .data     (data_vec[i]),
        .busy     (busy_vec[i])
      );
    end
  end

  // Read value with write-first bypass so a retiring result is visible
  // to a reader in the same cycle.
  function automatic logic [XLEN-1:0] read_val(input logic [AW-1:0] r);
    if (ZERO_REG && r == '0)      return '0;
    else if (writereg && rd == r) return writedata;
    else                          return data_vec[r];
  endfunction

  // Read-port next values.
  always_comb begin
    rdata1_d = read_val(rs1);
    rdata2_d = read_val(rs2);
  end

  // Read-port output registers (latency 1, no enable).
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  assign readdata1 = rdata1_q;
  assign readdata2 = rdata2_q;

  // Hazard: a busy source stalls unless its value is arriving through the
  // bypass this very cycle.
  always_comb begin
    hazard = (busy_vec[rs1] && !(writereg && rd == rs1)) ||
             (busy_vec[rs2] && !(writereg && rd == rs2));
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default instance (32x32, zero reg)
// and a 16x64 instance with register 0 as an ordinary register.
module tb_reg_file_sb;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] r1;
    logic [63:0] r2;
    logic [31:0] bv;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- default instance ----------------
  logic        reset, writereg, issue_valid;
  logic [4:0]  rd, rs1, rs2, issue_rd;
  logic [31:0] writedata, readdata1, readdata2, busy_vec;
  logic        hazard;

  reg_file_sb dut (
    .clock(clock), .reset(reset), .writereg(writereg), .rd(rd),
    .writedata(writedata), .rs1(rs1), .rs2(rs2),
    .readdata1(readdata1), .readdata2(readdata2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hazard(hazard), .busy_vec(busy_vec)
  );

  logic [31:0] m_arr [32];
  logic [31:0] m_bsy;

  function automatic logic [31:0] mval(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (writereg && rd == r) return writedata;
    return m_arr[r];
  endfunction

  task automatic step(input string tag);
    exp_t e;
    logic hz;
    hz = (m_bsy[rs1] && !(writereg && rd == rs1)) || (m_bsy[rs2] && !(writereg && rd == rs2));
    if (reset) begin
      e.r1 = 0; e.r2 = 0;
      for (int i = 0; i < 32; i++) m_arr[i] = 0;
      m_bsy = 0;
    end else begin
      e.r1 = 64'(mval(rs1));
      e.r2 = 64'(mval(rs2));
      if (writereg && rd != 0) m_arr[rd] = writedata;
      if (writereg) m_bsy[rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_bsy[issue_rd] = 1'b1;
    end
    e.bv = m_bsy;
    exp_q.push_back(e);
    #1;
    chk({tag, ".hazard"}, 64'(hazard), 64'(hz));
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".rd1"}, 64'(readdata1), e.r1);
    chk({tag, ".rd2"}, 64'(readdata2), e.r2);
    chk({tag, ".busy"}, 64'(busy_vec), 64'(e.bv));
  endtask

  task automatic idle();
    reset = 0; writereg = 0; issue_valid = 0;
  endtask

  // ---------------- 16x64, no zero register ----------------
  logic        reset_w, writereg_w, issue_valid_w;
  logic [3:0]  rd_w, rs1_w, rs2_w, issue_rd_w;
  logic [63:0] writedata_w, readdata1_w, readdata2_w;
  logic [15:0] busy_vec_w;
  logic        hazard_w;

  reg_file_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(1'b0)) dut_w (
    .clock(clock), .reset(reset_w), .writereg(writereg_w), .rd(rd_w),
    .writedata(writedata_w), .rs1(rs1_w), .rs2(rs2_w),
    .readdata1(readdata1_w), .readdata2(readdata2_w),
    .issue_valid(issue_valid_w), .issue_rd(issue_rd_w),
    .hazard(hazard_w), .busy_vec(busy_vec_w)
  );

  logic [63:0] w_arr [16];
  logic [15:0] w_bsy;

  function automatic logic [63:0] wval(input logic [3:0] r);
    if (writereg_w && rd_w == r) return writedata_w;
    return w_arr[r];
  endfunction

  task automatic step_w(input string tag);
    exp_t e;
    logic hz;
    hz = (w_bsy[rs1_w] && !(writereg_w && rd_w == rs1_w)) ||
         (w_bsy[rs2_w] && !(writereg_w && rd_w == rs2_w));
    if (reset_w) begin
      e.r1 = 0; e.r2 = 0;
      for (int i = 0; i < 16; i++) w_arr[i] = 0;
      w_bsy = 0;
    end else begin
      e.r1 = wval(rs1_w);
      e.r2 = wval(rs2_w);
      if (writereg_w) begin
        w_arr[rd_w] = writedata_w;
        w_bsy[rd_w] = 1'b0;
      end
      if (issue_valid_w) w_bsy[issue_rd_w] = 1'b1;
    end
    e.bv = 32'(w_bsy);
    exp_q.push_back(e);
    #1;
    chk({tag, ".hazard"}, 64'(hazard_w), 64'(hz));
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".rd1"}, readdata1_w, e.r1);
    chk({tag, ".rd2"}, readdata2_w, e.r2);
    chk({tag, ".busy"}, 64'(busy_vec_w), 64'(e.bv));
  endtask

  task automatic idle_w();
    reset_w = 0; writereg_w = 0; issue_valid_w = 0;
  endtask

  initial begin
    reset = 1; writereg = 0; issue_valid = 0; rd = 0; rs1 = 0; rs2 = 0;
    issue_rd = 0; writedata = 0;
    reset_w = 1; writereg_w = 0; issue_valid_w = 0; rd_w = 0; rs1_w = 0;
    rs2_w = 0; issue_rd_w = 0; writedata_w = 0;
    for (int i = 0; i < 32; i++) m_arr[i] = 'x;
    for (int i = 0; i < 16; i++) w_arr[i] = 'x;
    m_bsy = 'x; w_bsy = 'x;
    #1;

    // reset both instances for two cycles
    step("rst0"); step("rst1");
    reset_w = 1; step_w("w.rst0"); step_w("w.rst1");
    reset_w = 0;

    // zero register ignores writes
    idle(); writereg = 1; rd = 0; writedata = 32'hDEADBEEF; step("zero.wr");
    idle(); rs1 = 0; step("zero.rd");

    // write then read on both ports
    writereg = 1; rd = 5; writedata = 32'h12345678; step("wr5");
    idle(); rs1 = 5; rs2 = 5; step("rd5");

    // bypass
    writereg = 1; rd = 7; writedata = 32'hA5A5A5A5; rs2 = 7; step("byp7");
    idle(); step("byp7.hold");

    // scoreboard hazard and clear
    issue_valid = 1; issue_rd = 3; step("iss3");
    idle(); rs1 = 3; rs2 = 5; step("haz3");
    writereg = 1; rd = 3; writedata = 32'h33; step("wb3");
    idle(); step("post3");

    // simultaneous set and clear
    issue_valid = 1; issue_rd = 9; step("iss9");
    issue_valid = 1; issue_rd = 9; writereg = 1; rd = 9; writedata = 32'h99; step("setclr9");
    idle(); rs1 = 9; rs2 = 9; step("rd9");

    // issuing to r0 never marks it busy
    issue_valid = 1; issue_rd = 0; rs1 = 0; step("iss0");

    // reset mid-operation
    idle(); issue_valid = 1; issue_rd = 4; writereg = 1; rd = 4; writedata = 32'h1; step("pre4");
    reset = 1; writereg = 1; rd = 4; writedata = 32'hFFFF; rs1 = 4; step("rst4");
    idle(); rs1 = 4; rs2 = 9; step("rd4");

    // random traffic
    for (int n = 0; n < 60; n++) begin
      reset = ($urandom_range(0, 19) == 0);
      writereg = $urandom_range(0, 1); rd = 5'($urandom);
      writedata = $urandom; issue_valid = $urandom_range(0, 1);
      issue_rd = 5'($urandom); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      step("rnd");
    end
    idle();

    // 64-bit, register 0 is ordinary
    idle_w(); writereg_w = 1; rd_w = 0; writedata_w = 64'hCAFEF00D_12345678; step_w("w.wr0");
    idle_w(); rs1_w = 0; rs2_w = 0; step_w("w.rd0");
    writereg_w = 1; rd_w = 15; writedata_w = 64'h8000_0000_0000_0001; rs1_w = 15; step_w("w.byp15");
    idle_w(); issue_valid_w = 1; issue_rd_w = 0; step_w("w.iss0");
    idle_w(); rs1_w = 0; step_w("w.haz0");
    issue_valid_w = 1; issue_rd_w = 4; writereg_w = 1; rd_w = 4; writedata_w = 64'h1; step_w("w.pre4");
    reset_w = 1; writereg_w = 1; rd_w = 4; writedata_w = 64'hFF; step_w("w.rst4");
    idle_w(); rs1_w = 4; rs2_w = 0; step_w("w.rd4");
    for (int n = 0; n < 40; n++) begin
      reset_w = ($urandom_range(0, 19) == 0);
      writereg_w = $urandom_range(0, 1); rd_w = 4'($urandom);
      writedata_w = {$urandom, $urandom}; issue_valid_w = $urandom_range(0, 1);
      issue_rd_w = 4'($urandom); rs1_w = 4'($urandom); rs2_w = 4'($urandom);
      step_w("w.rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
